// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The loader fills the array in LOAD; the fetch stage reads it in RUN.
package imem_responder_pkg;

   localparam int IMEM_AW  = 14;
   localparam int XLEN     = 32;
   localparam int LD_CNT_W = 15;

   localparam logic [XLEN-1:0]     BUBBLE     = 32'h0;
   localparam logic [LD_CNT_W-1:0] LD_CNT_MAX = 15'd16384;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/imem_sram_1p.sv
// Single-port instruction store: synchronous write, registered read.
// Addresses at or beyond DEPTH drop writes and read back as the bubble word.
module imem_sram_1p
   import imem_responder_pkg::*;
#(
   parameter int DEPTH = 16384
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [IMEM_AW-1:0] addr_i,
   input  logic [XLEN-1:0]    wdata_i,
   output logic [XLEN-1:0]    rdata_o
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [XLEN-1:0] mem [DEPTH];
   logic            in_range;
   logic [IW-1:0]   idx;
   logic [XLEN-1:0] rdata_d;
   logic [XLEN-1:0] rdata_q;

   // Upper address bits must be zero for the word to exist in this array.
   generate
      if (IW >= IMEM_AW) begin : g_full_range
         assign in_range = 1'b1;
      end else begin : g_part_range
         assign in_range = (addr_i[IMEM_AW-1:IW] == '0);
      end
   endgenerate

   assign idx = addr_i[IW-1:0];

   always_ff @(posedge clk) begin
      if (we_i && in_range) begin
         mem[idx] <= wdata_i;
      end
   end

   always_comb begin
      rdata_d = BUBBLE;
      if (re_i && in_range) begin
         rdata_d = mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= BUBBLE;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a loader image in LOAD, then serves
// 1-cycle-latency fetches in RUN until reload or reset.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 16384
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IMEM_AW-1:0]  instr_addr,
   output logic [XLEN-1:0]     instr_from_mem,
   output logic                imem_busy,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [IMEM_AW-1:0]  ld_addr,
   input  logic [XLEN-1:0]     ld_data,
   input  logic                ld_last,
   input  logic                reload,
   output logic [LD_CNT_W-1:0] ld_count,
   output state_e              dbg_state
);

   // Loader handshake: a word transfers on any rising edge where
   // ld_valid && ld_ready; ld_valid while ld_ready is low is simply ignored.

   state_e                state_q, state_d;
   logic [LD_CNT_W-1:0]   count_q, count_d;
   logic                  valid_q, valid_d;
   logic                  accept;
   logic                  rd_en;
   logic                  mem_we;
   logic [IMEM_AW-1:0]    mem_addr;
   logic [XLEN-1:0]       mem_rdata;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      ld_ready = 1'b0;
      accept   = 1'b0;
      rd_en    = 1'b0;
      case (state_q)
         ST_LOAD: begin
            ld_ready = 1'b1;
            accept   = ld_valid;
            if (accept) begin
               if (count_q != LD_CNT_MAX) begin
                  count_d = count_q + 15'd1;
               end
               if (ld_last) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // Suppressing the read on reload keeps the first LOAD cycle a bubble.
            if (reload) begin
               state_d = ST_LOAD;
               count_d = '0;
            end else begin
               rd_en = 1'b1;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   assign valid_d = rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Reads only happen in RUN and writes only in LOAD, so one port suffices.
   assign mem_we   = accept && !rst;
   assign mem_addr = (state_q == ST_RUN) ? instr_addr : ld_addr;

   imem_sram_1p #(
      .DEPTH (DEPTH_WORDS)
   ) u_sram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (mem_we),
      .re_i    (rd_en),
      .addr_i  (mem_addr),
      .wdata_i (ld_data),
      .rdata_o (mem_rdata)
   );

   assign instr_from_mem = valid_q ? mem_rdata : BUBBLE;
   assign imem_busy      = !valid_q;
   assign ld_count       = count_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a default-depth instance and a 16-word
// instance share stimulus; expected values are hand-computed constants.
module tb_imem_responder;
   import imem_responder_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [IMEM_AW-1:0]  instr_addr = '0;
   logic                ld_valid = 1'b0;
   logic [IMEM_AW-1:0]  ld_addr = '0;
   logic [XLEN-1:0]     ld_data = '0;
   logic                ld_last = 1'b0;
   logic                reload = 1'b0;

   logic [XLEN-1:0]     instr_full, instr_small;
   logic                busy_full, busy_small;
   logic                ready_full, ready_small;
   logic [LD_CNT_W-1:0] count_full, count_small;
   state_e              state_full, state_small;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   imem_responder dut_full (
      .clk            (clk),
      .rst            (rst),
      .instr_addr     (instr_addr),
      .instr_from_mem (instr_full),
      .imem_busy      (busy_full),
      .ld_valid       (ld_valid),
      .ld_ready       (ready_full),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .ld_last        (ld_last),
      .reload         (reload),
      .ld_count       (count_full),
      .dbg_state      (state_full)
   );

   imem_responder #(.DEPTH_WORDS(16)) dut_small (
      .clk            (clk),
      .rst            (rst),
      .instr_addr     (instr_addr),
      .instr_from_mem (instr_small),
      .imem_busy      (busy_small),
      .ld_valid       (ld_valid),
      .ld_ready       (ready_small),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .ld_last        (ld_last),
      .reload         (reload),
      .ld_count       (count_small),
      .dbg_state      (state_small)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are stable and inputs safe to change.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [13:0] a, input logic [31:0] d, input logic last);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      ld_last  = last;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic read_addr(input logic [13:0] a);
      instr_addr = a;
      step();
   endtask

   task automatic check_mode(input string tag, input state_e st, input logic [14:0] cnt,
                             input logic busy, input logic rdy);
      check({tag, "_state"}, 32'(state_full), 32'(st));
      check({tag, "_count"}, 32'(count_full), 32'(cnt));
      check({tag, "_busy"},  32'(busy_full),  32'(busy));
      check({tag, "_ready"}, 32'(ready_full), 32'(rdy));
   endtask

   initial begin
      // Reset
      step();
      step();
      check_mode("reset", ST_LOAD, 15'd0, 1'b1, 1'b1);
      check("reset_instr", instr_full, 32'h0);
      rst = 1'b0;

      // Basic image load and fetch
      load_word(14'd0, 32'h00000013, 1'b0);
      check("load1_count", 32'(count_full), 32'd1);
      load_word(14'd1, 32'h00100093, 1'b0);
      load_word(14'd2, 32'h00200113, 1'b0);
      load_word(14'd3, 32'h00308193, 1'b1);
      check_mode("first_run", ST_RUN, 15'd4, 1'b1, 1'b0);
      check("first_run_instr", instr_full, 32'h0);
      read_addr(14'd0);
      check("rd0", instr_full, 32'h00000013);
      check("rd0_busy", 32'(busy_full), 32'd0);
      read_addr(14'd1);
      check("rd1", instr_full, 32'h00100093);
      read_addr(14'd2);
      check("rd2", instr_full, 32'h00200113);
      read_addr(14'd3);
      check("rd3", instr_full, 32'h00308193);

      // ld_valid held during RUN is ignored
      ld_valid = 1'b1;
      ld_addr  = 14'd3;
      ld_data  = 32'hBAD0BAD0;
      step();
      step();
      ld_valid = 1'b0;
      check("run_valid_count", 32'(count_full), 32'd4);
      check("run_valid_nowrite", instr_full, 32'h00308193);

      // Read then reload
      read_addr(14'd2);
      check("pre_reload_rd2", instr_full, 32'h00200113);
      reload = 1'b1;
      step();
      reload = 1'b0;
      check_mode("reload", ST_LOAD, 15'd0, 1'b1, 1'b1);
      check("reload_instr", instr_full, 32'h0);

      // Load with gaps, out-of-range word, reload in LOAD, reload with last
      load_word(14'd5, 32'h00000555, 1'b0);
      check("gap_cnt1", 32'(count_full), 32'd1);
      ld_addr = 14'd9;
      ld_data = 32'h99999999;
      step();
      check("gap_cnt_idle", 32'(count_full), 32'd1);
      load_word(14'd8, 32'hAAAA0008, 1'b0);
      check("gap_cnt2", 32'(count_full), 32'd2);
      load_word(14'd20, 32'h5555AAAA, 1'b0);
      check("oor_cnt_small", 32'(count_small), 32'd3);
      load_word(14'd12, 32'hEEEE000C, 1'b0);
      reload = 1'b1;
      step();
      reload = 1'b0;
      check_mode("reload_in_load", ST_LOAD, 15'd4, 1'b1, 1'b1);
      reload = 1'b1;
      load_word(14'd11, 32'hDDDD000B, 1'b1);
      reload = 1'b0;
      check_mode("last_beats_reload", ST_RUN, 15'd5, 1'b1, 1'b0);
      read_addr(14'd8);
      check("rd8", instr_full, 32'hAAAA0008);
      read_addr(14'd20);
      check("rd20_full", instr_full, 32'h5555AAAA);
      check("rd20_small", instr_small, 32'h0);
      read_addr(14'd2);
      check("rd2_retained", instr_full, 32'h00200113);
      check("rd2_small", instr_small, 32'h00200113);
      read_addr(14'd11);
      check("rd11", instr_full, 32'hDDDD000B);

      // Reset in RUN
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_mode("rst_run", ST_LOAD, 15'd0, 1'b1, 1'b1);
      check("rst_run_instr", instr_full, 32'h0);

      // Reset mid-load drops the in-flight word
      ld_valid = 1'b1;
      ld_addr  = 14'd5;
      ld_data  = 32'hDEADBEEF;
      rst      = 1'b1;
      step();
      rst      = 1'b0;
      ld_valid = 1'b0;
      check_mode("rst_load", ST_LOAD, 15'd0, 1'b1, 1'b1);
      load_word(14'd6, 32'h00000066, 1'b1);
      check("after_rst_count", 32'(count_full), 32'd1);
      read_addr(14'd5);
      check("rd5_kept", instr_full, 32'h00000555);
      check("rd5_kept_small", instr_small, 32'h00000555);
      read_addr(14'd11);
      check("rd11_after_rst", instr_full, 32'hDDDD000B);

      // Counter saturation; writes continue past the limit
      reload = 1'b1;
      step();
      reload = 1'b0;
      for (int i = 0; i < 16386; i++) begin
         ld_valid = 1'b1;
         ld_addr  = 14'(i);
         ld_data  = 32'(i);
         step();
         if (i == 16382) check("sat_cnt_16383", 32'(count_full), 32'd16383);
         if (i == 16383) check("sat_cnt_16384", 32'(count_full), 32'd16384);
      end
      ld_valid = 1'b0;
      check("sat_hold", 32'(count_full), 32'd16384);
      check("sat_hold_small", 32'(count_small), 32'd16384);
      load_word(14'd100, 32'hCAFEF00D, 1'b1);
      check_mode("sat_last", ST_RUN, 15'd16384, 1'b1, 1'b0);
      read_addr(14'd0);
      check("sat_rd0", instr_full, 32'h00004000);
      read_addr(14'd1);
      check("sat_rd1", instr_full, 32'h00004001);
      read_addr(14'd100);
      check("sat_rd100", instr_full, 32'hCAFEF00D);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
